geofence_feeder: RTL and testbench
==================================

Name: geofence_feeder

Overview:
- Upstream stage of the geofence engine.
- Accepts fence frames from a host over a valid/ready stream. Each frame is 7 points: target T first, then the six fence vertices.
- Buffers up to two frames and replays each on X/Y in the engine's fixed 26-cycle cadence.
- Holds the engine in reset whenever no complete frame is available, so the engine never consumes garbage points.

Parameters:
- W, 10, coordinate width; must match the engine's X/Y width.
- NPTS, 7, points per frame (T plus six vertices).
- PERIOD, 26, engine cycles per frame, from its first capture state through its final state.
- NBUF, 2, frame buffers (ping-pong).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  host point valid.
- in_ready  out  1  feeder can accept a point.
- in_x  in  W  point X.
- in_y  in  W  point Y.
- in_last  in  1  marks the final point of a frame.
- X  out  W  engine X input (registered).
- Y  out  W  engine Y input (registered).
- gf_reset  out  1  active-high reset to the engine (registered).
- frame_start  out  1  one-cycle pulse in the cycle T is driven.
- frame_err  out  1  one-cycle pulse when a malformed frame is discarded.

Behaviour:
- Reset (reset=0 at an edge):
  - X=0, Y=0, gf_reset=1, in_ready=0, frame_start=0, frame_err=0.
  - Both buffers empty; write index 0; phase 0; state IDLE.
  - Applies mid-frame too: any partial or full frame is dropped and the engine is held in reset.
  - in_ready goes 1 in the first cycle after reset is released.
- Input handshake:
  - A point transfers on an edge with in_valid & in_ready.
  - in_ready=1 iff the write buffer is not full. in_ready does not depend on in_valid.
  - Points are written to the write buffer at index 0..6.
- Framing:
  - Normal close: in_last on index 6 closes the frame. The buffer is marked full and the write pointer flips to the other buffer.
  - Error case 1: in_last on index <6. The partial frame is discarded, index returns to 0, and frame_err pulses on the next cycle.
  - Error case 2: index 6 accepted without in_last. Same discard and frame_err pulse. Accepting an 8th point is impossible.
- States:
  - IDLE (gf_reset=1, X=Y=0):
    - Read buffer full → STREAM.
    - On the same edge: gf_reset←0, phase←0, X/Y←point 0, frame_start←1.
  - STREAM: phase counts 0..PERIOD-1, one per cycle.
    - Phase k (k<7): X/Y hold point k.
    - Phase 7..25: X/Y=0.
    - The read buffer is released (marked empty) at the edge ending phase 6, so the host may refill it during phases 7..25.
  - Phase 25 edge:
    - If the other buffer is full: phase←0, gf_reset stays 0, X/Y←its point 0, frame_start←1. Back-to-back throughput is one frame per 26 cycles with no bubble.
    - Otherwise: gf_reset←1, X/Y←0, → IDLE.
- Latency: edge E accepts the 7th point with the feeder in IDLE → edge E+1 deasserts gf_reset and drives T. The engine captures T at E+2.
- Simultaneous events:
  - A frame may close on the same edge its sibling buffer is released; both updates take effect.
  - A frame closing on the phase-25 edge is not seen until the next check. That frame starts from IDLE 1 cycle later.
- Phase counter: 5 bits, wraps 25→0. Values 26..31 are unreachable; if reached, force IDLE with gf_reset=1.

Test Plan:
- Reset, then one frame T=(5,5), A..F=(0,0),(10,0),(10,10),(0,10),(0,5),(5,0) with in_last on point 7.
  - gf_reset falls 1 cycle after the last handshake.
  - X/Y show (5,5),(0,0)..(5,0) over 7 consecutive cycles, then 19 cycles of 0.
  - gf_reset rises after phase 25.
  - frame_start pulses once.
- Three frames offered back-to-back with in_valid held high.
  - in_ready drops after the 2nd frame is buffered.
  - The 3rd frame is accepted only after phase 6 of frame 1.
  - frame_start pulses are exactly 26 cycles apart.
  - gf_reset stays 0 throughout.
- in_last on point 3 → frame_err pulses once. No frame_start. The next well-formed frame streams normally.
- 7 points with no in_last → frame_err pulses. An immediately following valid frame is accepted starting at index 0.
- reset=0 asserted during phase 10 of a frame with a second frame buffered.
  - Next cycle: gf_reset=1, X=Y=0, in_ready=0.
  - After release, no stream starts until a new frame arrives.
- A frame completing on the phase-25 edge of the previous frame → gf_reset pulses high for exactly 1 cycle, then the new frame streams.

Source files
------------

// File: rtl/geofence_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : geofence_feeder
//  Description : Upstream stage of the geofence engine. Accepts 7-point fence
//                frames (target T, then six vertices) over a valid/ready
//                stream into a ping-pong buffer. Each complete frame is
//                replayed on X/Y in the engine's fixed 26-cycle cadence. The
//                engine is held in reset whenever no complete frame is ready.
//  Revision    : 1.0  initial release
// ============================================================================
module geofence_feeder #(
    parameter int W      = 10,
    parameter int NPTS   = 7,
    parameter int PERIOD = 26,
    parameter int NBUF   = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_x,
    input  logic [W-1:0] in_y,
    input  logic         in_last,
    output logic [W-1:0] X,
    output logic [W-1:0] Y,
    output logic         gf_reset,
    output logic         frame_start,
    output logic         frame_err
);

    localparam logic [0:0] c_IDLE       = 1'b0;
    localparam logic [0:0] c_STREAM     = 1'b1;
    localparam logic [2:0] c_LAST_IDX   = 3'(NPTS - 1);
    localparam logic [4:0] c_REL_PHASE  = 5'(NPTS - 1);
    localparam logic [4:0] c_LAST_PHASE = 5'(PERIOD - 1);

    // Frame storage: one slot of NPTS points per buffer
    logic [W-1:0]    r_buf_x [NBUF][NPTS];
    logic [W-1:0]    r_buf_y [NBUF][NPTS];

    logic [NBUF-1:0] r_full;
    logic [NBUF-1:0] w_full_next;
    logic            r_wr_sel;
    logic            r_rd_sel;
    logic [2:0]      r_wr_idx;
    logic [4:0]      r_phase;
    logic [0:0]      r_state;
    logic            r_ready_en;
    logic [W-1:0]    r_x;
    logic [W-1:0]    r_y;
    logic            r_gf_reset;
    logic            r_frame_start;
    logic            r_frame_err;

    logic            w_accept;
    logic            w_close;
    logic            w_release;
    logic [2:0]      w_nxt_idx;

    // r_ready_en keeps in_ready low during reset even though buffers are empty
    assign in_ready    = r_ready_en & ~r_full[r_wr_sel];
    assign w_accept    = in_valid & in_ready;
    assign w_close     = w_accept & in_last & (r_wr_idx == c_LAST_IDX);
    assign w_release   = (r_state == c_STREAM) & (r_phase == c_REL_PHASE);
    assign w_nxt_idx   = r_phase[2:0] + 3'd1;

    assign X           = r_x;
    assign Y           = r_y;
    assign gf_reset    = r_gf_reset;
    assign frame_start = r_frame_start;
    assign frame_err   = r_frame_err;

    // Release of the read buffer and close of the write buffer may coincide;
    // they always target different buffers, so both updates apply.
    always_comb begin
        w_full_next = r_full;
        if (w_release) w_full_next[r_rd_sel] = 1'b0;
        if (w_close)   w_full_next[r_wr_sel] = 1'b1;
    end

    // Point storage write; contents need no reset since r_full gates their use
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf_x[r_wr_sel][r_wr_idx] <= in_x;
            r_buf_y[r_wr_sel][r_wr_idx] <= in_y;
        end
    end

    // Write-side framing: close on in_last at the final index, discard otherwise
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ready_en  <= 1'b0;
            r_wr_sel    <= 1'b0;
            r_wr_idx    <= 3'd0;
            r_frame_err <= 1'b0;
            r_full      <= '0;
        end else begin
            r_ready_en  <= 1'b1;
            r_frame_err <= 1'b0;
            r_full      <= w_full_next;
            if (w_accept) begin
                if (w_close) begin
                    r_wr_sel <= ~r_wr_sel;
                    r_wr_idx <= 3'd0;
                end else if (in_last || (r_wr_idx == c_LAST_IDX)) begin
                    r_wr_idx    <= 3'd0;
                    r_frame_err <= 1'b1;
                end else begin
                    r_wr_idx <= r_wr_idx + 3'd1;
                end
            end
        end
    end

    // Read-side sequencer: IDLE holds the engine in reset, STREAM replays a frame
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= c_IDLE;
            r_phase       <= 5'd0;
            r_rd_sel      <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_gf_reset    <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            if (r_state == c_IDLE) begin
                if (r_full[r_rd_sel]) begin
                    r_state       <= c_STREAM;
                    r_phase       <= 5'd0;
                    r_gf_reset    <= 1'b0;
                    r_x           <= r_buf_x[r_rd_sel][0];
                    r_y           <= r_buf_y[r_rd_sel][0];
                    r_frame_start <= 1'b1;
                end else begin
                    r_gf_reset <= 1'b1;
                    r_x        <= '0;
                    r_y        <= '0;
                end
            end else if (r_phase > c_LAST_PHASE) begin
                // Unreachable phase values: recover to a safe idle
                r_state    <= c_IDLE;
                r_phase    <= 5'd0;
                r_gf_reset <= 1'b1;
                r_x        <= '0;
                r_y        <= '0;
            end else if (r_phase == c_LAST_PHASE) begin
                // r_rd_sel already points at the sibling buffer (flipped at release)
                if (r_full[r_rd_sel]) begin
                    r_phase       <= 5'd0;
                    r_x           <= r_buf_x[r_rd_sel][0];
                    r_y           <= r_buf_y[r_rd_sel][0];
                    r_frame_start <= 1'b1;
                end else begin
                    r_state    <= c_IDLE;
                    r_phase    <= 5'd0;
                    r_gf_reset <= 1'b1;
                    r_x        <= '0;
                    r_y        <= '0;
                end
            end else begin
                r_phase <= r_phase + 5'd1;
                if (r_phase < c_REL_PHASE) begin
                    r_x <= r_buf_x[r_rd_sel][w_nxt_idx];
                    r_y <= r_buf_y[r_rd_sel][w_nxt_idx];
                end else begin
                    r_x <= '0;
                    r_y <= '0;
                end
                if (w_release) r_rd_sel <= ~r_rd_sel;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_geofence_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_geofence_feeder
//  Description : Directed self-checking bench for geofence_feeder.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_geofence_feeder;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_x;
    logic [W-1:0] in_y;
    logic         in_last;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic         gf_reset;
    logic         frame_start;
    logic         frame_err;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    int           start_cyc[$];
    logic [W-1:0] start_x[$];
    int           last_gfr_cyc = 0;
    int           n_err = 0;

    geofence_feeder #(.W(W), .NPTS(7), .PERIOD(26), .NBUF(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_last     (in_last),
        .X           (X),
        .Y           (Y),
        .gf_reset    (gf_reset),
        .frame_start (frame_start),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    // Edge counter: after posedge n, cyc == n
    always @(posedge clk) cyc <= cyc + 1;

    // Event log sampled just after each active edge
    always begin
        @(posedge clk);
        #1;
        if (frame_start) begin
            start_cyc.push_back(cyc);
            start_x.push_back(X);
        end
        if (gf_reset)  last_gfr_cyc = cyc;
        if (frame_err) n_err++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Frame 0 is the square fence from the test plan; others are synthetic
    function automatic logic [W-1:0] px(input int f, input int k);
        logic [W-1:0] r;
        r = W'(f * 64 + k * 7 + 3);
        if (f == 0) begin
            case (k)
                0: r = 10'd5;   1: r = 10'd0;   2: r = 10'd10;  3: r = 10'd10;
                4: r = 10'd0;   5: r = 10'd0;   default: r = 10'd5;
            endcase
        end
        return r;
    endfunction

    function automatic logic [W-1:0] py(input int f, input int k);
        logic [W-1:0] r;
        r = W'(1000 - f * 50 - k * 9);
        if (f == 0) begin
            case (k)
                0: r = 10'd5;   1: r = 10'd0;   2: r = 10'd0;   3: r = 10'd10;
                4: r = 10'd10;  5: r = 10'd5;   default: r = 10'd0;
            endcase
        end
        return r;
    endfunction

    // Present one point and return at the negedge after its handshake edge
    task automatic send_point(input logic [W-1:0] x, input logic [W-1:0] y,
                              input logic last, output int hs_cyc);
        int t;
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        in_last  = last;
        t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        hs_cyc = cyc;
    endtask

    // in_valid is left high so consecutive frames are offered back-to-back
    task automatic send_frame(input int f, input int n, input int last_at,
                              output int first_hs, output int last_hs);
        int h;
        first_hs = 0;
        last_hs  = 0;
        for (int k = 0; k < n; k++) begin
            send_point(px(f, k), py(f, k), (k == last_at), h);
            if (k == 0) first_hs = h;
            last_hs = h;
        end
        in_last = 1'b0;
    endtask

    // Called at the negedge before the expected start; checks the full period
    task automatic check_stream(input int f, input string tag);
        @(negedge clk);
        check($sformatf("%s_p0", tag), {frame_start, gf_reset, X, Y},
              {1'b1, 1'b0, px(f, 0), py(f, 0)});
        for (int k = 1; k < 7; k++) begin
            @(negedge clk);
            check($sformatf("%s_p%0d", tag, k), {frame_start, gf_reset, X, Y},
                  {1'b0, 1'b0, px(f, k), py(f, k)});
        end
        for (int k = 7; k < 26; k++) begin
            @(negedge clk);
            check($sformatf("%s_p%0d", tag, k), {frame_start, gf_reset, X, Y}, 32'd0);
        end
        @(negedge clk);
        check($sformatf("%s_gfr_rise", tag), 32'(gf_reset), 32'd1);
    endtask

    initial begin
        int fa, la, fb, lb, fc, lc, fd, ld, fe, le, ff, lf, fg, lg;
        int n0, n1, e0, s1, s2, s3, t;

        reset    = 1'b0;
        in_valid = 1'b0;
        in_x     = '0;
        in_y     = '0;
        in_last  = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_outputs", {X, Y, gf_reset, frame_start, frame_err}, {20'd0, 1'b1, 1'b0, 1'b0});
        check("rst_ready", 32'(in_ready), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(in_ready), 32'd1);

        // Test 1: single frame, latency and full replay
        send_frame(0, 7, 6, fa, la);
        in_valid = 1'b0;
        check("t1_gfr_before", 32'(gf_reset), 32'd1);
        check_stream(0, "t1");
        check("t1_no_err", 32'(n_err), 32'd0);

        // Test 2: three frames back-to-back with in_valid held high
        n0 = start_cyc.size();
        send_frame(1, 7, 6, fa, la);
        send_frame(2, 7, 6, fb, lb);
        check("t2_ready_drop", 32'(in_ready), 32'd0);
        send_frame(3, 7, 6, fc, lc);
        in_valid = 1'b0;
        t = 0;
        while (start_cyc.size() < n0 + 3 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (start_cyc.size() < n0 + 3) begin
            check("t2_starts_timeout", 32'(start_cyc.size()), 32'(n0 + 3));
        end else begin
            s1 = start_cyc[n0];
            s2 = start_cyc[n0 + 1];
            s3 = start_cyc[n0 + 2];
            check("t2_latency", 32'(s1), 32'(la + 1));
            check("t2_gap12", 32'(s2 - s1), 32'd26);
            check("t2_gap23", 32'(s3 - s2), 32'd26);
            check("t2_third_wait", 32'(fc - s1), 32'd8);
            check("t2_t1", 32'(start_x[n0]), 32'(px(1, 0)));
            check("t2_t2", 32'(start_x[n0 + 1]), 32'(px(2, 0)));
            check("t2_t3", 32'(start_x[n0 + 2]), 32'(px(3, 0)));
            t = 0;
            while (cyc < s3 + 25 && t < 200) begin
                @(negedge clk);
                t++;
            end
            check("t2_gfr_low", 32'(last_gfr_cyc < s1), 32'd1);
            @(negedge clk);
            check("t2_gfr_rise", 32'(gf_reset), 32'd1);
        end

        // Test 3: in_last on the 3rd point is discarded
        n0 = start_cyc.size();
        e0 = n_err;
        send_frame(4, 3, 2, fa, la);
        in_valid = 1'b0;
        check("t3_err_pulse", 32'(frame_err), 32'd1);
        @(negedge clk);
        check("t3_err_end", 32'(frame_err), 32'd0);
        repeat (3) @(negedge clk);
        check("t3_err_once", 32'(n_err - e0), 32'd1);
        check("t3_no_start", 32'(start_cyc.size()), 32'(n0));
        check("t3_gfr_held", 32'(gf_reset), 32'd1);
        send_frame(5, 7, 6, fa, la);
        in_valid = 1'b0;
        check_stream(5, "t3");

        // Test 4: seven points without in_last, then an immediate good frame
        e0 = n_err;
        send_frame(6, 7, -1, fa, la);
        check("t4_err_pulse", 32'(frame_err), 32'd1);
        send_frame(7, 7, 6, fb, lb);
        in_valid = 1'b0;
        check("t4_good_back2back", 32'(fb), 32'(la + 1));
        check_stream(7, "t4");
        check("t4_err_once", 32'(n_err - e0), 32'd1);

        // Test 5: reset during phase 10 with a second frame buffered
        n0 = start_cyc.size();
        send_frame(1, 7, 6, fd, ld);
        send_frame(2, 7, 6, fe, le);
        in_valid = 1'b0;
        if (start_cyc.size() < n0 + 1) begin
            check("t5_start_missing", 32'(start_cyc.size()), 32'(n0 + 1));
        end else begin
            s1 = start_cyc[n0];
            check("t5_latency", 32'(s1), 32'(ld + 1));
            t = 0;
            while (cyc < s1 + 10 && t < 100) begin
                @(negedge clk);
                t++;
            end
            reset = 1'b0;
            @(negedge clk);
            check("t5_rst_out", {gf_reset, X, Y}, {1'b1, 20'd0});
            check("t5_rst_ready", 32'(in_ready), 32'd0);
            reset = 1'b1;
            n1 = start_cyc.size();
            repeat (40) @(negedge clk);
            check("t5_no_start", 32'(start_cyc.size()), 32'(n1));
            check("t5_gfr_held", 32'(gf_reset), 32'd1);
            check("t5_ready_back", 32'(in_ready), 32'd1);
        end

        // Test 6: frame closing on the phase-25 edge of the previous frame
        n0 = start_cyc.size();
        send_frame(3, 7, 6, ff, lf);
        in_valid = 1'b0;
        s1 = lf + 1;
        t = 0;
        while (cyc < s1 + 19 && t < 100) begin
            @(negedge clk);
            t++;
        end
        send_frame(4, 7, 6, fg, lg);
        in_valid = 1'b0;
        check("t6_close_edge", 32'(lg), 32'(s1 + 26));
        check("t6_gfr_bubble", 32'(gf_reset), 32'd1);
        check("t6_one_start", 32'(start_cyc.size()), 32'(n0 + 1));
        check_stream(4, "t6");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
